// File: rtl/usb_pkg.sv
// usb_pkg: types shared by the USB receive packet buffer.
//   BYTE_W / byte_t  : one received data byte.
//   wr_state_e       : write-side packet FSM states.
//   len_w()/len_t    : width of a packet length, derived from the maximum packet size.
package usb_pkg;

  localparam int BYTE_W      = 8;
  localparam int MAX_PKT_DEF = 64;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    END  = 2'd2
  } wr_state_e;

  // Enough bits to hold 0..max_pkt inclusive.
  function automatic int len_w(input int max_pkt);
    return $clog2(max_pkt + 1);
  endfunction

  typedef logic [len_w(MAX_PKT_DEF)-1:0] len_t;

endpackage

// File: rtl/usb_len_fifo.sv
// usb_len_fifo: small synchronous FIFO of packet lengths.
//   clk, rst   : clock, async active-high reset
//   clr_i      : synchronous clear, wins over push/pop
//   push_i     : write din_i (ignored when full)
//   pop_i      : drop head entry (ignored when empty)
//   dout_o     : head entry (combinational)
//   full_o, empty_o, count_o : occupancy status
module usb_len_fifo
  import usb_pkg::*;
#(
  parameter int W     = $bits(len_t),
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wp, r_rp;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_push, w_pop;

  assign count_o = r_wp - r_rp;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (r_wp == r_rp);
  assign dout_o  = r_mem[r_rp[AW-1:0]];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (clr_i) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !clr_i) r_mem[r_wp[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/usb_rx_pkt_fifo.sv
// usb_rx_pkt_fifo: speculative receive buffer between usb_fsm and the report consumer.
// Bytes of the packet being received are written ahead of the commit pointer and
// only become readable once the packet ends good; bad/aborted packets are rewound.
//   clk, rst      : clock, async active-high reset
//   wr_valid_i    : byte strobe, wr_data_i the byte, wr_last_i marks the final byte
//   wr_drop_i     : abort the packet in progress
//   flush_i       : discard everything (link disconnect); drop count kept
//   rd_valid_o/rd_ready_i/rd_data_o/rd_last_o : committed byte stream
//   pkt_count_o   : committed packets not yet fully read
//   drop_cnt_o    : saturating dropped-packet count
//   overflow_o    : pulse when a packet is dropped for space/length
// Optional: define USB_RX_CRC_STRIP_EN to strip the trailing CRC16 before commit.
module usb_rx_pkt_fifo
  import usb_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int PKT_DEPTH = 4,
  parameter int MAX_PKT   = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid_i,
  input  byte_t                        wr_data_i,
  input  logic                         wr_last_i,
  input  logic                         wr_drop_i,
  input  logic                         flush_i,
  input  logic                         rd_ready_i,
  output logic                         rd_valid_o,
  output byte_t                        rd_data_o,
  output logic                         rd_last_o,
  output logic [$clog2(PKT_DEPTH):0]   pkt_count_o,
  output logic [7:0]                   drop_cnt_o,
  output logic                         overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = len_w(MAX_PKT);

  wr_state_e      r_state;
  logic [PW-1:0]  r_wr_ptr, r_cm_ptr, r_rd_ptr;
  logic [LW-1:0]  r_len, r_rd_cnt;
  logic           r_bad, r_ovf;
  logic [7:0]     r_drop_cnt;
  byte_t          r_mem [DEPTH];

  logic           w_lf_full, w_lf_empty;
  logic [LW-1:0]  w_head_len;
  logic           w_rd_fire, w_pop;
  logic           w_commit, w_end_drop, w_inc_drop;
  logic [LW-1:0]  w_cm_len, w_len_cur;
  logic [PW-1:0]  w_cm_ptr, w_base;
  logic           w_start, w_full, w_store;

  // ---------------- read side ----------------
  assign rd_valid_o = (r_rd_ptr != r_cm_ptr);
  assign rd_data_o  = rd_valid_o ? r_mem[r_rd_ptr[AW-1:0]] : '0;
  assign rd_last_o  = rd_valid_o && (r_rd_cnt == w_head_len - LW'(1));
  assign w_rd_fire  = rd_valid_o && rd_ready_i;
  assign w_pop      = w_rd_fire && rd_last_o && !flush_i;

  // ---------------- END-cycle decision ----------------
  always_comb begin
    w_commit   = 1'b0;
    w_end_drop = 1'b0;
    w_cm_len   = r_len;
    w_cm_ptr   = r_wr_ptr;
`ifdef USB_RX_CRC_STRIP_EN
    w_cm_len   = r_len - LW'(2);
    w_cm_ptr   = r_wr_ptr - PW'(2);
`endif
    if (r_state == END && !wr_drop_i && !flush_i) begin
      if (r_bad)
        w_end_drop = 1'b1;
`ifdef USB_RX_CRC_STRIP_EN
      else if (r_len <= LW'(2))
        w_end_drop = 1'b0;   // CRC-only packet: vanish silently
`endif
      else if (w_lf_full)
        w_end_drop = 1'b1;
      else
        w_commit = 1'b1;
    end
  end

  assign w_inc_drop = !flush_i && (wr_drop_i || w_end_drop);

  // In END the next packet's first byte lands wherever the current packet
  // leaves the write pointer (after commit or rewind), so resolve that first.
  always_comb begin
    w_base = r_wr_ptr;
    if (r_state == END) w_base = w_commit ? w_cm_ptr : r_cm_ptr;
  end

  assign w_start   = wr_valid_i && (r_state != RECV);
  assign w_len_cur = w_start ? '0 : r_len;
  assign w_full    = ((w_base - r_rd_ptr) == PW'(DEPTH));
  assign w_store   = wr_valid_i && !w_full && (w_len_cur != LW'(MAX_PKT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_cm_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_len      <= '0;
      r_bad      <= 1'b0;
      r_rd_cnt   <= '0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_ovf <= 1'b0;
      if (flush_i) begin
        r_state  <= IDLE;
        r_wr_ptr <= '0;
        r_cm_ptr <= '0;
        r_rd_ptr <= '0;
        r_len    <= '0;
        r_bad    <= 1'b0;
        r_rd_cnt <= '0;
      end else begin
        if (w_rd_fire) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_rd_cnt <= rd_last_o ? '0 : r_rd_cnt + 1'b1;
        end
        if (w_commit) r_cm_ptr <= w_cm_ptr;
        if (w_inc_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
        if (wr_drop_i) begin
          r_wr_ptr <= r_cm_ptr;
          r_state  <= IDLE;
        end else begin
          if (w_end_drop) r_ovf <= 1'b1;
          r_wr_ptr <= w_base + PW'(w_store);
          if (wr_valid_i) begin
            r_state <= wr_last_i ? END : RECV;
            r_len   <= w_len_cur + LW'(w_store);
            r_bad   <= (w_start ? 1'b0 : r_bad) | !w_store;
          end else if (r_state == END) begin
            r_state <= IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_store && !wr_drop_i && !flush_i) r_mem[w_base[AW-1:0]] <= wr_data_i;
  end

  usb_len_fifo #(.W(LW), .DEPTH(PKT_DEPTH)) u_len_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush_i),
    .push_i  (w_commit),
    .din_i   (w_cm_len),
    .pop_i   (w_pop),
    .dout_o  (w_head_len),
    .full_o  (w_lf_full),
    .empty_o (w_lf_empty),
    .count_o (pkt_count_o)
  );

  assign drop_cnt_o = r_drop_cnt;
  assign overflow_o = r_ovf;

  // Length FIFO emptiness tracks rd_valid_o; kept only for debug visibility.
  logic w_unused;
  assign w_unused = w_lf_empty;

endmodule
